// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD step counter:
//   BCD_DIGITS  - number of packed BCD digits in the count word
//   BCD_MAX     - largest legal value of one BCD digit
//   deb_state_e - debounce FSM state encoding
//   bcd_valid() - true when every nibble of a packed word is a legal digit
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_MAX    = 9;
  localparam int BCD_W      = BCD_DIGITS * 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (value[i*4 +: 4] > 4'(BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// -----------------------------------------------------------------------------
// bcd_digit_step
// Combinational single-digit BCD adder used as one stage of a ripple chain.
//   digit_in  - current BCD digit (0-9)
//   addend    - value added to this digit (0-2; non-zero only on the LSD)
//   carry_in  - carry from the next less significant digit
//   digit_out - resulting BCD digit
//   carry_out - set when the sum exceeded BCD_MAX
// -----------------------------------------------------------------------------
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic [1:0] addend,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, digit_in} + {3'b000, addend} + {4'b0000, carry_in};
    if (sum > 5'(BCD_MAX)) begin
      digit_out = 4'(sum - 5'd10);
      carry_out = 1'b1;
    end else begin
      digit_out = sum[3:0];
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_step_counter.sv
// -----------------------------------------------------------------------------
// bcd_step_counter
// Four-digit BCD counter advanced by a debounced push button.
//   CLOCK_50    - sole clock, all state on rising edge
//   RESET_N     - asynchronous active-low reset
//   step_key_n  - raw push button, low = pressed, asynchronous
//   mode        - step size: 0 = +1, 1 = +2
//   enable      - when low, accepted presses leave count untouched
//   load        - synchronous load strobe (wins over a press in the same cycle)
//   load_value  - packed BCD load value, [15:12] most significant
//   count       - packed BCD count
//   step_pulse  - one cycle high when count first shows a stepped value
//   wrap        - one cycle high with step_pulse when the count passed 9999
//   load_err    - one cycle high when a load carried a non-BCD digit
// -----------------------------------------------------------------------------
module bcd_step_counter
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        step_key_n,
  input  logic        mode,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count,
  output logic        step_pulse,
  output logic        wrap,
  output logic        load_err
);

  localparam int            CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_N = CW'(DEBOUNCE_CYCLES);

  // Two-flop synchronizer; both flops reset to the released level.
  logic sync1_q, sync2_q;
  logic key_low;

  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          run_done;
  logic          accept;

  logic [15:0]   count_q, count_d;
  logic          step_pulse_q, step_pulse_d;
  logic          wrap_q, wrap_d;
  logic          load_err_q, load_err_d;

  logic [1:0]    step_addend;
  logic [15:0]   stepped;
  logic [BCD_DIGITS:0] carry;

  assign key_low = ~sync2_q;

  // cnt_q counts consecutive samples of the level being qualified; the
  // current sample is included, so the run completes when cnt_q+1 reaches N.
  assign cnt_inc  = cnt_q + 1'b1;
  assign run_done = (cnt_inc == DEB_N);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_low) begin
          if (run_done) begin
            state_d = HELD;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = cnt_inc;
          end
        end
      end
      PRESS_WAIT: begin
        if (!key_low) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (run_done) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!key_low) begin
          if (run_done) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = cnt_inc;
          end
        end
      end
      RELEASE_WAIT: begin
        // A low sample here is contact bounce on release: go back to HELD
        // without raising another accept.
        if (key_low) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (run_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ripple chain: only the least significant digit sees the step addend.
  assign step_addend = mode ? 2'd2 : 2'd1;
  assign carry[0]    = 1'b0;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      logic [1:0] addend;
      if (gi == 0) begin : g_lsd
        assign addend = step_addend;
      end else begin : g_upper
        assign addend = 2'd0;
      end
      bcd_digit_step u_digit (
        .digit_in  (count_q[gi*4 +: 4]),
        .addend    (addend),
        .carry_in  (carry[gi]),
        .digit_out (stepped[gi*4 +: 4]),
        .carry_out (carry[gi+1])
      );
    end
  endgenerate

  always_comb begin
    count_d      = count_q;
    step_pulse_d = 1'b0;
    wrap_d       = 1'b0;
    load_err_d   = 1'b0;
    if (load) begin
      // A load in the accept cycle swallows the step entirely.
      if (bcd_valid(load_value)) count_d = load_value;
      else                       load_err_d = 1'b1;
    end else if (accept && enable) begin
      count_d      = stepped;
      step_pulse_d = 1'b1;
      wrap_d       = carry[BCD_DIGITS];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      count_q      <= 16'h0000;
      step_pulse_q <= 1'b0;
      wrap_q       <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      sync1_q      <= step_key_n;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      step_pulse_q <= step_pulse_d;
      wrap_q       <= wrap_d;
      load_err_q   <= load_err_d;
    end
  end

  assign count      = count_q;
  assign step_pulse = step_pulse_q;
  assign wrap       = wrap_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_step_counter
// Self-checking bench for bcd_step_counter with DEBOUNCE_CYCLES = 4.
// A reference model (decimal integer count, run-length debounce) checks the
// outputs every cycle; a load table and hand-written press sequences add
// constant expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_bcd_step_counter;

  localparam int D = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        step_key_n;
  logic        mode;
  logic        enable;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        step_pulse;
  logic        wrap;
  logic        load_err;

  bcd_step_counter #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .step_key_n (step_key_n),
    .mode       (mode),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .step_pulse (step_pulse),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] b, output bit ok);
    int v;
    ok = 1'b1;
    v  = 0;
    for (int i = 3; i >= 0; i--) begin
      if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
      v = v * 10 + int'(b[i*4 +: 4]);
    end
    return v;
  endfunction

  // Raw key history: the debounce logic sees the key as it was two edges ago.
  bit m_h1 = 1'b1, m_h2 = 1'b1;
  bit m_level = 1'b1;
  int m_run = 0;
  bit m_pressed = 1'b0;
  int m_count = 0;
  bit m_pulse = 1'b0, m_wrap = 1'b0, m_err = 1'b0;

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    bit smp, acc, ok;
    int v;
    if (!RESET_N) begin
      m_h1 = 1'b1; m_h2 = 1'b1; m_level = 1'b1; m_run = 0; m_pressed = 1'b0;
      m_count = 0; m_pulse = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
    end else begin
      smp  = m_h2;
      m_h2 = m_h1;
      m_h1 = step_key_n;
      if (smp == m_level) m_run++;
      else begin m_level = smp; m_run = 1; end
      acc = 1'b0;
      if (!m_pressed && !m_level && m_run == D) begin m_pressed = 1'b1; acc = 1'b1; end
      if (m_pressed && m_level && m_run == D) m_pressed = 1'b0;
      m_pulse = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
      if (load) begin
        v = from_bcd(load_value, ok);
        if (ok) m_count = v;
        else    m_err = 1'b1;
      end else if (acc && enable) begin
        v       = m_count + (mode ? 2 : 1);
        m_wrap  = (v >= 10000);
        m_count = v % 10000;
        m_pulse = 1'b1;
      end
    end
  end

  bit chk_en = 1'b0;
  int p_cnt = 0, w_cnt = 0, both_cnt = 0;

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check("model_count", count, to_bcd(m_count));
      check("model_step_pulse", {15'd0, step_pulse}, {15'd0, m_pulse});
      check("model_wrap", {15'd0, wrap}, {15'd0, m_wrap});
      check("model_load_err", {15'd0, load_err}, {15'd0, m_err});
    end
    if (step_pulse) p_cnt++;
    if (wrap) w_cnt++;
    if (step_pulse && wrap) both_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge CLOCK_50);
      #1;
    end
  endtask

  task automatic press(input int low_cycles);
    step_key_n = 1'b0;
    tick(low_cycles);
    step_key_n = 1'b1;
    tick(12);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    tick();
    load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] value;
    logic [15:0] exp_count;
    logic        exp_err;
  } load_vec_t;

  load_vec_t lt[8];

  initial begin
    int p0, w0, b0, run_left;
    logic [15:0] rv;

    RESET_N = 1'b0; step_key_n = 1'b1; mode = 1'b0; enable = 1'b1;
    load = 1'b0; load_value = 16'h0000;
    tick(3);
    chk_en = 1'b1;
    check("reset_count", count, 16'h0000);
    check("reset_step_pulse", {15'd0, step_pulse}, 16'h0000);
    check("reset_wrap", {15'd0, wrap}, 16'h0000);
    check("reset_load_err", {15'd0, load_err}, 16'h0000);
    RESET_N = 1'b1;
    tick(2);

    // Clean press, no auto-repeat while held.
    p0 = p_cnt;
    press(10);
    check("clean_press_count", count, 16'h0001);
    check("clean_press_pulses", 16'(p_cnt - p0), 16'd1);

    // Bounce never reaches 4 consecutive low samples.
    p0 = p_cnt;
    step_key_n = 1'b0; tick(3);
    step_key_n = 1'b1; tick(1);
    step_key_n = 1'b0; tick(3);
    step_key_n = 1'b1; tick(12);
    check("bounce_count", count, 16'h0001);
    check("bounce_pulses", 16'(p_cnt - p0), 16'd0);
    // Exactly 4 low samples is a full press again.
    press(4);
    check("after_bounce_press", count, 16'h0002);

    // Wrap with +2 from 9999.
    do_load(16'h9999);
    mode = 1'b1;
    p0 = p_cnt; w0 = w_cnt; b0 = both_cnt;
    press(10);
    check("wrap_count", count, 16'h0001);
    check("wrap_pulses", 16'(w_cnt - w0), 16'd1);
    check("wrap_with_step", 16'(both_cnt - b0), 16'd1);
    mode = 1'b0;

    // Rejected load, then a carry across digits.
    load = 1'b1; load_value = 16'h12A4;
    tick();
    check("bad_load_err", {15'd0, load_err}, 16'h0001);
    load = 1'b0;
    tick();
    check("bad_load_err_cleared", {15'd0, load_err}, 16'h0000);
    check("bad_load_count", count, 16'h0001);
    do_load(16'h0899);
    press(10);
    check("carry_press_count", count, 16'h0900);

    // Load held across the accept cycle wins; enable=0 consumes the press.
    p0 = p_cnt;
    step_key_n = 1'b0;
    tick(3);
    load = 1'b1; load_value = 16'h0500;
    tick(5);
    load = 1'b0;
    tick(4);
    step_key_n = 1'b1;
    tick(12);
    check("load_vs_accept_count", count, 16'h0500);
    check("load_vs_accept_pulses", 16'(p_cnt - p0), 16'd0);
    enable = 1'b0;
    press(10);
    check("disabled_count", count, 16'h0500);
    check("disabled_pulses", 16'(p_cnt - p0), 16'd0);
    enable = 1'b1;

    // Reset during PRESS_WAIT with the key held down.
    do_load(16'h0042);
    tick();
    p0 = p_cnt;
    step_key_n = 1'b0;
    tick(4);
    RESET_N = 1'b0;
    #1;
    check("midpress_reset_count", count, 16'h0000);
    tick();
    RESET_N = 1'b1;
    tick(5);
    check("post_reset_no_early_accept", 16'(p_cnt - p0), 16'd0);
    tick();
    check("post_reset_accept", 16'(p_cnt - p0), 16'd1);
    check("post_reset_count", count, 16'h0001);
    step_key_n = 1'b1;
    tick(12);

    // Load table.
    lt[0] = '{16'h1234, 16'h1234, 1'b0};
    lt[1] = '{16'h9999, 16'h9999, 1'b0};
    lt[2] = '{16'h0A00, 16'h9999, 1'b1};
    lt[3] = '{16'h0000, 16'h0000, 1'b0};
    lt[4] = '{16'hF000, 16'h0000, 1'b1};
    lt[5] = '{16'h5678, 16'h5678, 1'b0};
    lt[6] = '{16'h567A, 16'h5678, 1'b1};
    lt[7] = '{16'h9090, 16'h9090, 1'b0};
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; load_value = lt[i].value;
      tick();
      load = 1'b0;
      check($sformatf("load_tab%0d_count", i), count, lt[i].exp_count);
      check($sformatf("load_tab%0d_err", i), {15'd0, load_err}, {15'd0, lt[i].exp_err});
      tick();
    end

    // 9998 + 2 wraps to 0000.
    do_load(16'h9998);
    mode = 1'b1;
    w0 = w_cnt;
    press(10);
    check("wrap9998_count", count, 16'h0000);
    check("wrap9998_pulses", 16'(w_cnt - w0), 16'd1);

    // Randomized phase, checked by the model each cycle.
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        step_key_n = ~step_key_n;
        run_left   = $urandom_range(1, 9);
      end
      run_left--;
      mode   = 1'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      load   = ($urandom_range(0, 19) == 0);
      for (int d = 0; d < 4; d++) begin
        rv[d*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0) rv = 16'h9998 + 16'($urandom_range(0, 1));
      load_value = rv;
      RESET_N = ($urandom_range(0, 799) != 0);
      tick();
    end
    RESET_N = 1'b1; load = 1'b0; step_key_n = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_step_counter.md
BCD_STEP_COUNTER -- requirements
Module: bcd_step_counter

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable synchronized samples needed to accept a key change (20 ms at 50 MHz).
REQ-002 The block SHALL expose port CLOCK_50  input  1  sole clock, 50 MHz, all state on rising edge.
REQ-003 The block SHALL expose port RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL expose port step_key_n  input  1  raw push button, low = pressed, asynchronous to CLOCK_50.
REQ-005 The block SHALL expose port mode  input  1  step size; 0 = +1, 1 = +2.
REQ-006 The block SHALL expose port enable  input  1  when low, accepted steps do not change count.
REQ-007 The block SHALL expose port load  input  1  synchronous load strobe, level-sampled each cycle.
REQ-008 The block SHALL expose port load_value  input  16  four packed BCD digits, [15:12] most significant.
REQ-009 The block SHALL expose port count  output  16  four packed BCD digits, feeding the per-digit 7-segment decoders.
REQ-010 The block SHALL expose port step_pulse  output  1  one-cycle pulse on each applied step.
REQ-011 The block SHALL expose port wrap  output  1  one-cycle pulse when a step passes 9999.
REQ-012 The block SHALL expose port load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 step_key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debounce FSM SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-015 IDLE->PRESS_WAIT SHALL occur on synchronized key low; PRESS_WAIT SHALL return to IDLE if the key goes high before DEBOUNCE_CYCLES consecutive low samples.
REQ-016 PRESS_WAIT->HELD SHALL occur on the DEBOUNCE_CYCLES-th consecutive low sample, and that transition SHALL generate exactly one internal accept.
REQ-017 HELD->RELEASE_WAIT SHALL occur on key high; RELEASE_WAIT->IDLE SHALL occur after DEBOUNCE_CYCLES consecutive high samples; a low sample in RELEASE_WAIT SHALL return to HELD without a new accept.
REQ-018 Holding the key SHALL produce no auto-repeat.
REQ-019 An accept with enable=1 and load=0 SHALL update count to (count + step) mod 10000 in BCD on the same clock edge, with step selected by mode as sampled in that cycle.
REQ-020 Per-digit rule: sum = digit + addend + carry_in; if sum > 9, result = sum - 10 and carry_out = 1.
REQ-021 Only the least significant digit SHALL receive the addend; the other digits SHALL receive only the carry.
REQ-022 step_pulse SHALL be high for the one cycle in which count first shows the stepped value.
REQ-023 wrap SHALL pulse in the same cycle as step_pulse when the top digit produces a carry (9999+1 -> 0000, 9999+2 -> 0001, 9998+2 -> 0000).
REQ-024 An accept with enable=0 SHALL be consumed with no count change, no step_pulse and no wrap.
REQ-025 load=1 with all load_value digits <= 9 SHALL set count = load_value on the next edge.
REQ-026 load=1 with any digit > 9 SHALL leave count unchanged and pulse load_err for one cycle.
REQ-027 load and accept in the same cycle: load SHALL win, the step SHALL be dropped, and step_pulse/wrap SHALL stay low.
REQ-028 load has no effect on the debounce FSM.
REQ-029 count SHALL always hold valid BCD digits (0-9 each).

Reset
REQ-030 RESET_N low SHALL asynchronously force count = 16'h0000, step_pulse = 0, wrap = 0, load_err = 0, FSM = IDLE, debounce counter = 0 and synchronizer flops = 1 (released).
REQ-031 Reset asserted mid-debounce or mid-press SHALL abort the operation; after release a still-held key SHALL be treated as a new press requiring a full DEBOUNCE_CYCLES low.
REQ-032 Reset deassertion SHALL be synchronized to CLOCK_50 externally; the block SHALL take no action in the first cycle after release beyond normal sampling.

Structure
REQ-033 Shared package bcd_pkg SHALL hold BCD_DIGITS = 4, BCD_MAX = 9, and the debounce state enumeration type.
REQ-034 Sub-module bcd_digit_step (4-bit digit, 2-bit addend, carry_in -> 4-bit digit, carry_out; combinational) SHALL be instantiated BCD_DIGITS times in a ripple chain.
REQ-035 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES = 4)
REQ-036 Reset, then a clean 10-cycle press, mode=0, enable=1 -> count 0000 -> 0001, one step_pulse, no second step while held.
REQ-037 Key bouncing low 3 cycles, high 1, low 3, then released -> no accept, count unchanged, FSM back in IDLE.
REQ-038 Load 9999 then press with mode=1 -> count 0001, wrap and step_pulse both high for one cycle.
REQ-039 Load 16'h12A4 -> load_err pulse, count unchanged; load 16'h0899 then press with mode=0 -> 0900.
REQ-040 Load 16'h0500 asserted in the accept cycle -> count 0500, no step_pulse; same press with enable=0 -> no change.
REQ-041 RESET_N low in PRESS_WAIT with the key held -> count 0000 immediately, and an accept only after 4 further low samples post-release.
